// File: rtl/m_axis_pattern_pkg.sv
// Shared types and the pattern-update rule for the AXI-Stream pattern generator.
// Pure definitions: no state, no timing of its own.
package m_axis_pattern_pkg;

  localparam int unsigned MAX_W = 512;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_DECR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Operates on a zero-extended value; width selects the live bit range so one
  // function serves every DATA_W (the rotate wraps at bit width-1, not MAX_W-1).
  function automatic logic [MAX_W-1:0] next_value(input mode_e             mode,
                                                  input logic [MAX_W-1:0] data,
                                                  input logic [MAX_W-1:0] step,
                                                  input int unsigned      width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] res;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    case (mode)
      MODE_INCR:  res = data + step;
      MODE_DECR:  res = data - step;
      MODE_CONST: res = data;
      default:    res = (data << 1) | (data >> (width - 1));
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/m_axis_pattern_datapath.sv
// tdata register: loads the seed on a run launch, advances by one pattern step per
// accepted beat, holds while the beat is stalled.
module m_axis_pattern_datapath
  import m_axis_pattern_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load_i,
  input  logic              adv_i,
  input  mode_e             mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [DATA_W-1:0] step_i,
  output logic [DATA_W-1:0] tdata_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] step_q;
  mode_e             mode_q;

  assign data_d  = DATA_W'(next_value(mode_q, MAX_W'(data_q), MAX_W'(step_q), DATA_W));
  assign tdata_o = data_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_q <= '0;
      step_q <= '0;
      mode_q <= MODE_INCR;
    end else if (load_i) begin
      data_q <= seed_i;
      step_q <= step_i;
      mode_q <= mode_i;
    end else if (adv_i) begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/m_axis_pattern_gen.sv
// Packetised AXI-Stream pattern source; first beat one cycle after start, 1 beat/cycle.
// Backpressure: tdata/tvalid/tlast held while tready is low; tvalid never depends on tready.
module m_axis_pattern_gen
  import m_axis_pattern_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PKT_LEN_W  = 16,
  parameter int unsigned NUM_PKTS_W = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_W-1:0]     cfg_seed,
  input  logic [DATA_W-1:0]     cfg_step,
  input  logic [PKT_LEN_W-1:0]  cfg_pkt_len,
  input  logic [NUM_PKTS_W-1:0] cfg_num_pkts,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_PKTS_W-1:0] pkt_count
);

  state_e                state_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  stop_req_q;
  logic [NUM_PKTS_W-1:0] pkt_count_q;
  logic [NUM_PKTS_W-1:0] pkt_count_d;
  logic [NUM_PKTS_W-1:0] num_pkts_q;
  logic [PKT_LEN_W-1:0]  pkt_len_q;
  logic [PKT_LEN_W-1:0]  beat_q;
  logic [PKT_LEN_W-1:0]  beat_d;

  logic hs;
  logic start_ok;
  logic final_pkt;

  assign hs          = tvalid_q & m_axis_tready;
  assign start_ok    = (state_q == ST_IDLE) & start & (cfg_pkt_len != '0);
  assign pkt_count_d = pkt_count_q + NUM_PKTS_W'(1);
  assign beat_d      = beat_q + PKT_LEN_W'(1);
  // An abort arriving on the closing handshake still makes this packet the last.
  assign final_pkt   = ((num_pkts_q != '0) && (pkt_count_d == num_pkts_q)) || stop_req_q || abort;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_req_q  <= 1'b0;
      pkt_count_q <= '0;
      num_pkts_q  <= '0;
      pkt_len_q   <= '0;
      beat_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q     <= ST_RUN;
            tvalid_q    <= 1'b1;
            tlast_q     <= (cfg_pkt_len == PKT_LEN_W'(1));
            busy_q      <= 1'b1;
            stop_req_q  <= 1'b0;
            pkt_count_q <= '0;
            beat_q      <= '0;
            pkt_len_q   <= cfg_pkt_len;
            num_pkts_q  <= cfg_num_pkts;
          end
        end
        ST_RUN: begin
          if (abort) stop_req_q <= 1'b1;
          if (hs) begin
            if (tlast_q) begin
              pkt_count_q <= pkt_count_d;
              beat_q      <= '0;
              if (final_pkt) begin
                state_q  <= ST_FINISH;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                tlast_q <= (pkt_len_q == PKT_LEN_W'(1));
              end
            end else begin
              beat_q  <= beat_d;
              tlast_q <= (beat_d == pkt_len_q - PKT_LEN_W'(1));
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  m_axis_pattern_datapath #(.DATA_W(DATA_W)) u_datapath (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load_i  (start_ok),
    .adv_i   (hs),
    .mode_i  (mode_e'(cfg_mode)),
    .seed_i  (cfg_seed),
    .step_i  (cfg_step),
    .tdata_o (m_axis_tdata)
  );

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_m_axis_pattern_gen.sv
// Bench for m_axis_pattern_gen: expected beats queued at launch, checked by a monitor.
module tb_m_axis_pattern_gen;

  localparam int DW = 8;
  localparam int LW = 16;
  localparam int NW = 16;

  localparam int INCR = 0, DECR = 1, CONST = 2, WALK = 3;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          start, abort;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed, cfg_step;
  logic [LW-1:0] cfg_pkt_len;
  logic [NW-1:0] cfg_num_pkts;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tready;
  logic          busy, done;
  logic [NW-1:0] pkt_count;

  always #5 aclk = ~aclk;

  m_axis_pattern_gen #(.DATA_W(DW), .PKT_LEN_W(LW), .NUM_PKTS_W(NW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .abort         (abort),
    .cfg_mode      (cfg_mode),
    .cfg_seed      (cfg_seed),
    .cfg_step      (cfg_step),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_num_pkts  (cfg_num_pkts),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready),
    .busy          (busy),
    .done          (done),
    .pkt_count     (pkt_count)
  );

  typedef struct {
    int data;
    bit last;
    bit fin;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   hs_cnt, mon_pkts, exp_pkts, rdy_mode, tog_idx;
  bit   run_done, done_pending, busy_pending, pkt_pending, prev_stall, prev_last;
  int   prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference step rule in plain integer arithmetic on 8-bit values.
  function automatic int ref_next(input int mode, input int d, input int step);
    case (mode)
      INCR:    return (d + step) % 256;
      DECR:    return (d - step + 256) % 256;
      CONST:   return d;
      default: return (d == 0) ? 0 : ((d * 2) % 256 + d / 128);
    endcase
  endfunction

  initial begin
    tready  = 1'b1;
    tog_idx = 0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       tready = 1'b1;
        1:       begin tready = (tog_idx % 3 == 0); tog_idx++; end
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      if (done_pending) begin
        check("done_pulse", done, 1);
        check("finish_tvalid", tvalid, 0);
        check("finish_busy", busy, 1);
        check("final_pkt_count", pkt_count, exp_pkts);
        done_pending = 0;
        busy_pending = 1;
        run_done     = 1;
      end else begin
        if (busy_pending) begin
          check("idle_busy", busy, 0);
          busy_pending = 0;
        end
        check("done_spurious", done, 0);
      end
      if (pkt_pending) begin
        check("pkt_count", pkt_count, mon_pkts);
        pkt_pending = 0;
      end
      if (prev_stall) begin
        check("stall_tvalid", tvalid, 1);
        check("stall_tdata", tdata, prev_data);
        check("stall_tlast", tlast, prev_last);
      end
      if (tvalid && tready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", tdata, 64'hDEAD);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("tdata", tdata, e.data);
          check("tlast", tlast, e.last);
          hs_cnt++;
          if (e.last) begin
            mon_pkts++;
            pkt_pending = 1;
          end
          if (e.fin) done_pending = 1;
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = int'(tdata);
      prev_last  = tlast;
    end
  end

  task automatic wait_run_end();
    for (int c = 0; c < 5000 && !run_done; c++) begin
      @(posedge aclk);
      #1;
    end
    check("run_end", run_done, 1);
    check("queue_empty", q.size(), 0);
  endtask

  task automatic run_start(input int mode, input int seed, input int step, input int len,
                           input int num, input int abort_at, input bit wait_end);
    int   npk, total, v;
    exp_t e;
    npk   = (num != 0) ? num : (abort_at / len + 1);
    total = npk * len;
    v     = seed;
    for (int i = 0; i < total; i++) begin
      e.data = v;
      e.last = (i % len == len - 1);
      e.fin  = (i == total - 1);
      q.push_back(e);
      v = ref_next(mode, v, step);
    end
    exp_pkts = npk;
    hs_cnt   = 0;
    mon_pkts = 0;
    run_done = 0;
    start        = 1'b1;
    cfg_mode     = 2'(mode);
    cfg_seed     = DW'(seed);
    cfg_step     = DW'(step);
    cfg_pkt_len  = LW'(len);
    cfg_num_pkts = NW'(num);
    @(posedge aclk);
    #1;
    start        = 1'b0;
    cfg_mode     = 2'($urandom);
    cfg_seed     = DW'($urandom);
    cfg_step     = DW'($urandom);
    cfg_pkt_len  = LW'($urandom);
    cfg_num_pkts = NW'($urandom);
    check("start_tvalid", tvalid, 1);
    check("start_busy", busy, 1);
    check("start_pkt_count", pkt_count, 0);
    if (num == 0) begin
      for (int c = 0; c < 3000 && hs_cnt != abort_at; c++) begin
        @(posedge aclk);
        #1;
      end
      check("abort_reached", hs_cnt, abort_at);
      abort = 1'b1;
      @(posedge aclk);
      #1;
      abort = 1'b0;
    end
    if (wait_end) wait_run_end();
  endtask

  initial begin
    aresetn = 1'b0;
    start = 1'b0; abort = 1'b0;
    cfg_mode = '0; cfg_seed = '0; cfg_step = '0; cfg_pkt_len = '0; cfg_num_pkts = '0;
    rdy_mode = 0;
    run_done = 0; done_pending = 0; busy_pending = 0; pkt_pending = 0; prev_stall = 0;
    hs_cnt = 0; mon_pkts = 0; exp_pkts = 0; prev_data = 0; prev_last = 0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pkt_count", pkt_count, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // abort while idle must not shorten the following run
    abort = 1'b1;
    @(posedge aclk);
    #1;
    abort = 1'b0;
    run_start(INCR, 0, 1, 4, 2, 0, 1);

    // toggling ready plus an ignored start mid-run
    rdy_mode = 1;
    run_start(INCR, 0, 1, 4, 2, 0, 0);
    repeat (3) begin @(posedge aclk); #1; end
    start = 1'b1; cfg_mode = 2'(CONST); cfg_seed = 8'hAA; cfg_pkt_len = 16'd1; cfg_num_pkts = 16'd1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    wait_run_end();

    rdy_mode = 0;
    run_start(DECR, 2, 3, 3, 1, 0, 1);
    run_start(WALK, 1, 0, 9, 0, 4, 1);

    // zero packet length is refused
    start = 1'b1; cfg_pkt_len = '0; cfg_num_pkts = 16'd1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    repeat (4) begin
      check("len0_busy", busy, 0);
      check("len0_tvalid", tvalid, 0);
      @(posedge aclk);
      #1;
    end

    rdy_mode = 2;
    for (int r = 0; r < 14; r++) begin
      int m, len, num;
      m   = $urandom_range(0, 3);
      len = $urandom_range(1, 6);
      num = $urandom_range(0, 4);
      run_start(m, $urandom_range(0, 255), $urandom_range(0, 255), len, num,
                $urandom_range(0, len * 3), 1);
    end

    // asynchronous reset in the middle of a packet
    rdy_mode = 0;
    run_start(INCR, 0, 1, 4, 1, 0, 0);
    for (int c = 0; c < 50 && hs_cnt != 1; c++) begin
      @(posedge aclk);
      #1;
    end
    check("rst_mid_reached", hs_cnt, 1);
    #3;
    aresetn = 1'b0;
    #1;
    check("arst_tvalid", tvalid, 0);
    check("arst_tlast", tlast, 0);
    check("arst_tdata", tdata, 0);
    check("arst_busy", busy, 0);
    check("arst_pkt_count", pkt_count, 0);
    q.delete();
    done_pending = 0; busy_pending = 0; pkt_pending = 0; prev_stall = 0;
    @(posedge aclk);
    #1;
    check("arst_hold_tvalid", tvalid, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    run_start(INCR, 8'h5A, 1, 2, 1, 0, 1);

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
